// File: rtl/add8u_err_monitor_if.sv
// Sample bus between the approximate-adder source and the error monitor.
// Carries one operand pair, its approximate sum, and a valid/ready handshake.
interface add8u_err_monitor_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W:0]   in_o;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_o,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_o,
        output in_ready
    );
endinterface

// File: rtl/add8u_err_monitor.sv
// Error-statistics monitor for 8-bit unsigned approximate adders.
// Each accepted sample is compared with the exact sum.  Over a batch of
// n_samples the block accumulates the error count, the sum of |error|, the
// sum of error^2 and the worst-case error together with its operands.
// Two pipeline stages sit between accept and the accumulators.
module add8u_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int ABS_W = CNT_W + W + 1,
    parameter int SQ_W  = CNT_W + 2 * (W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         n_samples,
    add8u_err_monitor_if.slave       in_if,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [ABS_W-1:0]         sum_abs_err,
    output logic [SQ_W-1:0]          sum_sq_err,
    output logic [W:0]               max_err,
    output logic [W-1:0]             max_err_a,
    output logic [W-1:0]             max_err_b
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam int               SQR_W   = 2 * (W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Magnitude of a signed difference; |d| <= 2^(W+1)-1 always fits in W+1 bits.
    function automatic logic [W:0] abs_mag(input logic signed [W+1:0] d);
        logic signed [W+1:0] m;
        m = (d < 0) ? -d : d;
        return m[W:0];
    endfunction

    // Exact square of a (W+1)-bit magnitude.
    function automatic logic [SQR_W-1:0] square(input logic [W:0] m);
        logic [SQR_W-1:0] mx;
        mx = {{(W+1){1'b0}}, m};
        return mx * mx;
    endfunction

    state_t             state_q, state_d;
    logic               busy_q, done_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   acc_q;
    logic               in_ready;
    logic               accept;
    logic               start_go;

    // Stage 1 registers
    logic               vld_p1_q;
    logic [W-1:0]       a_p1_q, b_p1_q;
    logic signed [W+1:0] d_p1_q;
    logic [W:0]         exact_p1_d;
    logic signed [W+1:0] d_p1_d;

    // Stage 2 registers
    logic               vld_p2_q;
    logic [W-1:0]       a_p2_q, b_p2_q;
    logic [W:0]         abs_p2_q;
    logic [SQR_W-1:0]   sq_p2_q;

    // Accumulators
    logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;
    logic [ABS_W-1:0]   sum_abs_q;
    logic [SQ_W-1:0]    sum_sq_q;
    logic [W:0]         max_err_q;
    logic [W-1:0]       max_a_q, max_b_q;

    assign in_ready       = (state_q == RUN) && (acc_q < n_q);
    assign in_if.in_ready = in_ready;
    assign accept         = in_if.in_valid & in_ready;
    assign start_go       = (state_q == IDLE) && start;

    assign exact_p1_d = {1'b0, in_if.in_a} + {1'b0, in_if.in_b};
    assign d_p1_d     = $signed({1'b0, in_if.in_o}) - $signed({1'b0, exact_p1_d});

    // Next-state selection for the batch controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (n_samples == '0) ? DRAIN : RUN;
            RUN:     if (accept && (acc_q + CNT_ONE == n_q)) state_d = DRAIN;
            DRAIN:   if (!vld_p1_q && !vld_p2_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Batch controller: state, registered busy/done, batch length and accept count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            n_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (start_go) begin
                n_q   <= n_samples;
                acc_q <= '0;
            end else if (accept) begin
                acc_q <= acc_q + CNT_ONE;
            end
        end
    end

    // Pipeline valids are control and are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
        end
    end

    // Stage 1 -> stage 2 data path: exact sum difference, then magnitude and square.
    always_ff @(posedge clk) begin
        a_p1_q   <= in_if.in_a;
        b_p1_q   <= in_if.in_b;
        d_p1_q   <= d_p1_d;
        a_p2_q   <= a_p1_q;
        b_p2_q   <= b_p1_q;
        abs_p2_q <= abs_mag(d_p1_q);
        sq_p2_q  <= square(abs_mag(d_p1_q));
    end

    // Statistics accumulation; cleared by reset or by an honoured start.
    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_abs_q    <= '0;
            sum_sq_q     <= '0;
            max_err_q    <= '0;
            max_a_q      <= '0;
            max_b_q      <= '0;
        end else if (vld_p2_q) begin
            sample_cnt_q <= sample_cnt_q + CNT_ONE;
            if (abs_p2_q != '0) err_cnt_q <= err_cnt_q + CNT_ONE;
            sum_abs_q <= sum_abs_q + ABS_W'(abs_p2_q);
            sum_sq_q  <= sum_sq_q + SQ_W'(sq_p2_q);
            // Strict compare keeps the first sample on a tie.
            if (abs_p2_q > max_err_q) begin
                max_err_q <= abs_p2_q;
                max_a_q   <= a_p2_q;
                max_b_q   <= b_p2_q;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign sum_abs_err = sum_abs_q;
    assign sum_sq_err  = sum_sq_q;
    assign max_err     = max_err_q;
    assign max_err_a   = max_a_q;
    assign max_err_b   = max_b_q;

endmodule

// File: doc/add8u_err_monitor.md
Name: add8u_err_monitor

Overview:
- Downstream characterization stage for the 8-bit unsigned approximate adders.
- Consumes each operand pair (A, B) together with the approximate sum O produced by the adder under test, and computes the exact sum internally.
- Accumulates error statistics over a programmed batch of samples: error count (EP), sum of |error| (MAE), sum of error² (MSE) and worst-case error (WCE) with its operands.
- Results are read out once the batch completes and used by the hardware-in-the-loop evaluation harness.

Parameters:
- W, 8: operand width; the approximate sum is W+1 bits.
- CNT_W, 16: width of the sample counter and of n_samples.
- ABS_W, CNT_W+W+1: width of sum_abs_err.
- SQ_W, CNT_W+2*(W+1): width of sum_sq_err.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new batch; honoured only in IDLE.
- n_samples  in  CNT_W  batch length; latched when start is honoured.
- in_valid  in  1  a sample is present on in_a/in_b/in_o.
- in_ready  out  1  block accepts a sample this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_o  in  W+1  approximate sum from the adder under test.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the results are final.
- sample_cnt  out  CNT_W  number of samples accepted.
- err_cnt  out  CNT_W  number of samples with in_o != in_a+in_b.
- sum_abs_err  out  ABS_W  Σ|in_o − (in_a+in_b)|.
- sum_sq_err  out  SQ_W  Σ(in_o − (in_a+in_b))².
- max_err  out  W+1  largest |error| seen in the batch.
- max_err_a  out  W  in_a of the first sample reaching max_err.
- max_err_b  out  W  in_b of the first sample reaching max_err.

Behaviour:
- Reset: state IDLE; all outputs and internal pipeline valids are 0. Reset mid-batch aborts the batch; no done pulse is produced.
- States:
  - IDLE: start=1 clears all statistics, latches n_samples and goes to RUN. If n_samples=0 it goes to DRAIN instead.
  - RUN: in_ready = (accepted < n_latched). A sample is accepted when in_valid & in_ready. After the n-th accept, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Results hold their values in IDLE until the next start or rst.
- start outside IDLE is ignored. in_valid while in_ready=0 is ignored; no sample is consumed.
- Pipeline, 2 stages:
  - S1 registers exact = in_a+in_b (W+1 bits, zero-extended), the signed difference d = in_o − exact (W+2 bits), and the operands.
  - S2 computes |d| (fits in W+1 bits) and d², and updates the accumulators.
  - A sample accepted at edge t is reflected in all outputs after edge t+2.
- sample_cnt increments at S2 together with the other statistics, not at accept.
- err_cnt increments when d != 0.
- max_err and the operand capture update only when |d| > max_err (strict), so on a tie the first occurrence is kept. The initial max is 0, so error-free batches report max_err=0 and max_err_a/max_err_b=0.
- Accumulators are sized so that they cannot overflow for n ≤ 2^CNT_W−1; no saturation logic is needed.
- Timing: done is high in the cycle after the last sample's statistics land. If the last accept is at edge t, done is high in the cycle after edge t+3. For n_samples=0, done pulses 2 cycles after start, with all results 0.
- in_ready is combinational from state and the accept counter only; it has no dependency on in_valid.

Test Plan:
- Reset, then n_samples=4 with samples (10,20,O=30), (255,255,O=510), (1,1,O=0), (100,50,O=153) → sample_cnt=4, err_cnt=2, sum_abs_err=5, sum_sq_err=13, max_err=3, max_err_a=100, max_err_b=50, and a single done pulse.
- Tie handling: n=2 with (5,5,O=8) then (7,7,O=16) → max_err=2, captured operands (5,5), err_cnt=2.
- Backpressure and gaps: n=3, in_valid toggled every other cycle and held high after the 3rd accept → in_ready drops after the 3rd accept, sample_cnt=3, extra beats are ignored.
- n_samples=0 → busy for 2 cycles, done pulse, all statistics 0. A start issued during RUN of a following batch has no effect.
- rst asserted mid-batch after 2 accepts → all outputs 0 on the next cycle, state IDLE, no done pulse. A fresh start then runs normally.
- Exhaustive sweep: n=65535 with (A,B) covering all 8-bit pairs except (255,255) and O=A+B−1 (clamped at 0) → err_cnt=65534, sum_abs_err=65534, max_err=1, with the first error at A=0,B=1.
